// File: rtl/alu_accum_stage.sv
// rtl/alu_accum_stage.sv - result register stage with accumulate feedback, sticky carry and op counter
//
// Purpose:
//   Holds the 8-bit ALU result in Q, handing it downstream with a valid/ready
//   handshake. Q[3:0] is fed back as the ALU B operand so consecutive operations
//   accumulate. Also tracks a sticky add-carry flag and a saturating count of
//   accepted operations.
//
// Ports:
//   Clock      in   1      rising-edge clock
//   Reset_b    in   1      asynchronous active-low reset
//   ALUout     in   8      combinational ALU result for the current A, B_fb, Function
//   Function   in   2      ALU function select (0 add, 1 OR, 2 AND, 3 concat)
//   Clear      in   1      synchronous clear of Q, CarryFlag, OpCount and result slot
//   op_valid   in   1      upstream presents an operation
//   op_ready   out  1      stage accepts the operation this cycle
//   res_ready  in   1      downstream consumes Q
//   res_valid  out  1      Q holds an unconsumed result
//   B_fb       out  4      feedback operand to ALU B input
//   Q          out  8      registered result
//   CarryFlag  out  1      sticky carry from accepted adds
//   OpCount    out  CNT_W  accepted-operation count, saturating at all-ones

module alu_accum_stage #(
   parameter int CNT_W       = 8,
   parameter bit FEEDBACK_EN = 1'b1
) (
   input  logic             Clock,
   input  logic             Reset_b,
   input  logic [7:0]       ALUout,
   input  logic [1:0]       Function,
   input  logic             Clear,
   input  logic             op_valid,
   output logic             op_ready,
   input  logic             res_ready,
   output logic             res_valid,
   output logic [3:0]       B_fb,
   output logic [7:0]       Q,
   output logic             CarryFlag,
   output logic [CNT_W-1:0] OpCount
);

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t state;
   state_t state_next;
   logic   accept;

   always_ff @(posedge Clock or negedge Reset_b) begin
      if (!Reset_b) begin
         state <= EMPTY;
      end else begin
         state <= state_next;
      end
   end

   // op_ready depends only on state, res_ready, Clear and reset, never on
   // op_valid, so upstream may wait for ready before raising valid.
   always_comb begin
      state_next = state;
      op_ready   = 1'b0;
      res_valid  = 1'b0;
      accept     = 1'b0;

      case (state)
         EMPTY: begin
            op_ready = Reset_b && !Clear;
         end
         FULL: begin
            res_valid = 1'b1;
            // A consuming downstream frees the slot, so a new op can land
            // in the same cycle without a bubble.
            op_ready  = Reset_b && !Clear && res_ready;
         end
         default: begin
            op_ready = 1'b0;
         end
      endcase

      accept = op_valid && op_ready;

      if (Clear) begin
         state_next = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) state_next = FULL;
            end
            FULL: begin
               if (res_ready && !accept) state_next = EMPTY;
            end
            default: begin
               state_next = EMPTY;
            end
         endcase
      end
   end

   always_ff @(posedge Clock or negedge Reset_b) begin
      if (!Reset_b) begin
         Q         <= 8'h00;
         CarryFlag <= 1'b0;
         OpCount   <= '0;
      end else if (Clear) begin
         Q         <= 8'h00;
         CarryFlag <= 1'b0;
         OpCount   <= '0;
      end else if (accept) begin
         Q <= ALUout;
         if (Function == 2'd0 && ALUout[4]) begin
            CarryFlag <= 1'b1;
         end
         if (OpCount != {CNT_W{1'b1}}) begin
            OpCount <= OpCount + 1'b1;
         end
      end
   end

   assign B_fb = FEEDBACK_EN ? Q[3:0] : 4'b0000;

endmodule
